event_blinker: RTL and testbench
================================

Name: event_blinker

Overview:
- Output-side counterpart of the debounced button edge detectors.
- Turns single-cycle event strobes from internal logic into human-visible LED pulses of fixed on-time, separated by a fixed off-gap.
- Events arriving while a blink is in progress are queued in a saturating counter and replayed in order, so no strobe is silently lost until the queue is full.
- Sits between control logic and an LED pin.

Parameters:
- ON_CYCLES, 5000000, LED on-time in clock cycles (50 ms at 100 MHz); legal range >=1.
- OFF_CYCLES, 5000000, minimum LED off-gap between consecutive blinks in clock cycles; legal range >=1.
- MAX_PENDING, 7, maximum number of queued events; legal range >=1.
- PEND_W, clog2(MAX_PENDING+1), width of the pending counter; derived, do not override.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- IN  input  1  event strobe; every cycle sampled high counts as one event.
- OUT  output  1  registered LED drive; high during a blink.
- BUSY  output  1  registered; high whenever state is not IDLE.
- PENDING  output  PEND_W  registered count of queued, not-yet-started events.
- OVERFLOW  output  1  registered one-cycle pulse when an event is dropped.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (RESET low): immediately and without a clock, force state=IDLE, OUT=0, BUSY=0, PENDING=0, OVERFLOW=0, timer=0. Hold these while RESET is low. The first update occurs on the first CLK rising edge after release.
- State machine: three states, IDLE, ON and OFF. A single down-counter timer is sized for max(ON_CYCLES, OFF_CYCLES)-1.
- IDLE:
  - IN=1 -> go to ON with OUT<=1 and timer<=ON_CYCLES-1. PENDING is unchanged.
  - Latency: IN sampled high at edge k gives OUT high from edge k onward (visible in cycle k+1).
- ON:
  - timer!=0 -> decrement timer.
  - timer==0 -> go to OFF with OUT<=0 and timer<=OFF_CYCLES-1.
  - OUT is high for exactly ON_CYCLES cycles.
- OFF:
  - timer!=0 -> decrement timer.
  - timer==0 and (PENDING>0 or IN=1) -> go to ON with OUT<=1 and timer<=ON_CYCLES-1.
  - timer==0 otherwise -> go to IDLE.
  - The gap is exactly OFF_CYCLES cycles.
- Queue rules, evaluated every edge in ON or OFF (never in IDLE):
  - Increment: IN=1 and not consumed at this edge -> PENDING+1 if PENDING<MAX_PENDING. Otherwise PENDING holds and OVERFLOW<=1 for one cycle.
  - Consume: the OFF->ON transition consumes one event, taken from IN if IN=1, else from PENDING (decrement).
  - Simultaneous case: OFF expiry with IN=1 and PENDING>0 leaves PENDING unchanged (IN consumed directly), so net zero.
  - Order is irrelevant because all events are identical; only the count matters.
- OVERFLOW:
  - Is 0 on every edge with no drop.
  - Never asserts in IDLE, because IDLE always accepts.
- BUSY is registered alongside the state: BUSY<=1 on entry to ON, BUSY<=0 on entry to IDLE.
- Throughput: back-to-back blinks with period ON_CYCLES+OFF_CYCLES while the queue is non-empty.
- Reset mid-blink: aborts immediately (OUT low asynchronously) and discards the queue. No blink resumes after release.

Test Plan:
All scenarios use ON_CYCLES=3, OFF_CYCLES=2, MAX_PENDING=2. Edges are numbered from the first IN sample.
1. Assert RESET low mid-simulation with no clock edge -> OUT=0, BUSY=0, PENDING=0, OVERFLOW=0 immediately. Release, IN=0 for 20 cycles -> all outputs stay 0.
2. Single IN pulse at edge 0 -> OUT high for cycles 1-3, low from cycle 4. BUSY high for cycles 1-5, low from cycle 6. PENDING stays 0.
3. IN high at edges 0, 1, 2 -> PENDING=1 after edge 1 and 2 after edge 2. Three blinks, OUT high in cycles 1-3, 6-8 and 11-13. PENDING drops to 1 at edge 5 and 0 at edge 10. BUSY falls after edge 15.
4. IN high at edges 0-3 -> PENDING saturates at 2 after edge 2. OVERFLOW high for exactly cycle 4 (after edge 3). Exactly 3 blinks total.
5. IN at edge 0, then RESET low during cycle 2 (OUT high) -> OUT falls immediately and PENDING=0. After release with IN=0 -> no further blinks and BUSY=0.
6. Queue one event (PENDING=1), then drive IN=1 exactly at the OFF-expiry edge -> new blink starts, PENDING remains 1, and the second replayed blink follows after the next OFF gap.

Source files
------------

// File: rtl/event_blinker_if.sv
// event_blinker_if: event strobe in, LED drive and queue status out
interface event_blinker_if #(
  parameter int PEND_W = 3
);
  logic IN;
  logic OUT;
  logic BUSY;
  logic [PEND_W-1:0] PENDING;
  logic OVERFLOW;
  modport master (output IN, input OUT, BUSY, PENDING, OVERFLOW);
  modport slave (input IN, output OUT, BUSY, PENDING, OVERFLOW);
endinterface

// File: rtl/event_blinker.sv
// event_blinker: turns event strobes into fixed-length LED blinks, queueing events that arrive mid-blink
module event_blinker #(
  parameter int ON_CYCLES = 5000000,
  parameter int OFF_CYCLES = 5000000,
  parameter int MAX_PENDING = 7,
  parameter int PEND_W = $clog2(MAX_PENDING + 1)
) (
  input logic CLK,
  input logic RESET,
  event_blinker_if.slave bus
);
  localparam int T_MAX = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
  localparam int TW = T_MAX > 1 ? $clog2(T_MAX) : 1;
  localparam logic [TW-1:0] ON_T = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_T = TW'(OFF_CYCLES - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON = 2'd1;
  localparam logic [1:0] OFF = 2'd2;
  logic [1:0] state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [PEND_W-1:0] pending, pending_n;
  logic out_q, busy_q, ovf_q;
  logic on_done, expire, start, inc, dec, drop;
  // A strobe coincident with the OFF expiry starts the blink itself, so it never touches the queue
  always_comb begin
    on_done = state == ON && timer == '0;
    expire = state == OFF && timer == '0;
    start = (state == IDLE && bus.IN) || (expire && (bus.IN || pending != '0));
    inc = state != IDLE && bus.IN && !start;
    drop = inc && pending == PEND_W'(MAX_PENDING);
    dec = expire && !bus.IN && pending != '0;
    state_n = start ? ON : on_done ? OFF : expire ? IDLE : state;
    timer_n = start ? ON_T : on_done ? OFF_T : timer != '0 ? timer - TW'(1) : timer;
    pending_n = dec ? pending - PEND_W'(1) : (inc && !drop) ? pending + PEND_W'(1) : pending;
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state <= IDLE;
      timer <= '0;
      pending <= '0;
      out_q <= 1'b0;
      busy_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      pending <= pending_n;
      out_q <= state_n == ON;
      busy_q <= state_n != IDLE;
      ovf_q <= drop;
    end
  assign bus.OUT = out_q;
  assign bus.BUSY = busy_q;
  assign bus.PENDING = pending;
  assign bus.OVERFLOW = ovf_q;
endmodule

// File: tb/tb_event_blinker.sv
// tb_event_blinker: directed scenarios with ON=3, OFF=2, MAX_PENDING=2
module tb_event_blinker;
  localparam int ON = 3;
  localparam int OFF = 2;
  localparam int MAXP = 2;
  localparam int PW = 2;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int checks = 0;
  int errors = 0;
  logic out_h[32];
  logic busy_h[32];
  logic ov_h[32];
  logic [PW-1:0] pend_h[32];
  event_blinker_if #(.PEND_W(PW)) bus ();
  event_blinker #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .MAX_PENDING(MAXP)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );
  always #5 CLK = ~CLK;
  // bit k of pat is IN at edge k; history index k holds outputs just after edge k
  task automatic run(input logic [31:0] pat, input int n);
    for (int k = 0; k < n; k++) begin
      bus.IN = pat[k];
      @(posedge CLK);
      #1;
      out_h[k] = bus.OUT;
      busy_h[k] = bus.BUSY;
      ov_h[k] = bus.OVERFLOW;
      pend_h[k] = bus.PENDING;
    end
    bus.IN = 1'b0;
  endtask
  task automatic test_reset;
    run(32'b11, 2);
    checks++;
    if (bus.OUT !== 1'b1 || bus.PENDING !== 2'd1) begin
      errors++;
      $display("FAIL reset_pre out=%b pending=%0d required out=1 pending=1", bus.OUT, bus.PENDING);
    end
    #2 RESET = 1'b0;
    #1;
    checks++;
    if ({bus.OUT, bus.BUSY, bus.PENDING, bus.OVERFLOW} !== 5'b0) begin
      errors++;
      $display("FAIL reset_async out=%b busy=%b pending=%0d ovf=%b required all 0", bus.OUT, bus.BUSY, bus.PENDING, bus.OVERFLOW);
    end
    @(posedge CLK);
    #1 RESET = 1'b1;
    run(32'b0, 20);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if ({out_h[k], busy_h[k], pend_h[k], ov_h[k]} !== 5'b0) begin
        errors++;
        $display("FAIL reset_idle edge %0d out=%b busy=%b pending=%0d ovf=%b required all 0", k, out_h[k], busy_h[k], pend_h[k], ov_h[k]);
      end
    end
  endtask
  task automatic test_single;
    logic [9:0] eo, eb;
    eo = 10'b0000000111;
    eb = 10'b0000011111;
    run(32'b1, 10);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (out_h[k] !== eo[k] || busy_h[k] !== eb[k] || pend_h[k] !== 2'd0 || ov_h[k] !== 1'b0) begin
        errors++;
        $display("FAIL single edge %0d out=%b busy=%b pending=%0d ovf=%b required out=%b busy=%b pending=0 ovf=0", k, out_h[k], busy_h[k], pend_h[k], ov_h[k], eo[k], eb[k]);
      end
    end
  endtask
  task automatic test_back_to_back;
    logic [19:0] eo, eb;
    int ep[20];
    eo = 20'b0000000_111_00_111_00_111;
    eb = 20'b00000_111111111111111;
    ep = '{0, 1, 2, 2, 2, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run(32'b111, 20);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (out_h[k] !== eo[k] || busy_h[k] !== eb[k] || pend_h[k] !== PW'(ep[k]) || ov_h[k] !== 1'b0) begin
        errors++;
        $display("FAIL back_to_back edge %0d out=%b busy=%b pending=%0d ovf=%b required out=%b busy=%b pending=%0d ovf=0", k, out_h[k], busy_h[k], pend_h[k], ov_h[k], eo[k], eb[k], ep[k]);
      end
    end
  endtask
  task automatic test_overflow;
    logic [24:0] eo, eov;
    int rises;
    logic prev;
    eo = 25'b000000000000_111_00_111_00_111;
    eov = 25'b1000;
    rises = 0;
    prev = 1'b0;
    run(32'b1111, 25);
    for (int k = 0; k < 25; k++) begin
      checks++;
      if (out_h[k] !== eo[k] || ov_h[k] !== eov[k]) begin
        errors++;
        $display("FAIL overflow edge %0d out=%b ovf=%b required out=%b ovf=%b", k, out_h[k], ov_h[k], eo[k], eov[k]);
      end
      if (out_h[k] && !prev) rises++;
      prev = out_h[k];
    end
    checks++;
    if (pend_h[3] !== 2'd2 || rises != 3) begin
      errors++;
      $display("FAIL overflow_count pending=%0d blinks=%0d required pending=2 blinks=3", pend_h[3], rises);
    end
  endtask
  task automatic test_reset_mid_blink;
    run(32'b11, 2);
    #2 RESET = 1'b0;
    #1;
    checks++;
    if (bus.OUT !== 1'b0 || bus.PENDING !== 2'd0 || bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset out=%b busy=%b pending=%0d required 0 0 0", bus.OUT, bus.BUSY, bus.PENDING);
    end
    @(posedge CLK);
    #1 RESET = 1'b1;
    run(32'b0, 15);
    for (int k = 0; k < 15; k++) begin
      checks++;
      if (out_h[k] !== 1'b0 || busy_h[k] !== 1'b0 || pend_h[k] !== 2'd0) begin
        errors++;
        $display("FAIL mid_reset_after edge %0d out=%b busy=%b pending=%0d required 0 0 0", k, out_h[k], busy_h[k], pend_h[k]);
      end
    end
  endtask
  task automatic test_expiry_in;
    logic [19:0] eo, eb;
    int ep[20];
    eo = 20'b0000000_111_00_111_00_111;
    eb = 20'b00000_111111111111111;
    ep = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run(32'b100011, 20);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (out_h[k] !== eo[k] || busy_h[k] !== eb[k] || pend_h[k] !== PW'(ep[k]) || ov_h[k] !== 1'b0) begin
        errors++;
        $display("FAIL expiry_in edge %0d out=%b busy=%b pending=%0d ovf=%b required out=%b busy=%b pending=%0d ovf=0", k, out_h[k], busy_h[k], pend_h[k], ov_h[k], eo[k], eb[k], ep[k]);
      end
    end
  endtask
  initial begin
    bus.IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({bus.OUT, bus.BUSY, bus.PENDING, bus.OVERFLOW} !== 5'b0) begin
      errors++;
      $display("FAIL power_on_reset out=%b busy=%b pending=%0d ovf=%b required all 0", bus.OUT, bus.BUSY, bus.PENDING, bus.OVERFLOW);
    end
    RESET = 1'b1;
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_reset_mid_blink;
    test_expiry_in;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
